seg_buf_arbiter: RTL and testbench

//  - Owns the 32-bit hex buffer that feeds the 8-digit seven-segment scanner (digit 7 = buffer[31:28]).
//  - Shares write access between two requesters using round-robin arbitration:
//      - req0: CPU GPIO bus port.
//      - req1: debug/trace source.
//  - Applies nibble-granular writes; drives the scanner's buffer input directly.

---
 rtl/seg_buf_arbiter_pkg.sv | 29 ++
 rtl/seg_blink_timer.sv | 26 ++
 rtl/seg_buf_arbiter.sv | 110 +++++++++++
 tb/tb_seg_buf_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_buf_arbiter_pkg.sv
// Shared definitions for the seven-segment buffer arbiter: FSM states,
// register addresses, requester ids and the nibble-merge helper.
package seg_buf_arbiter_pkg;

  typedef enum logic {
    SEG_ST_IDLE  = 1'b0,
    SEG_ST_WRITE = 1'b1
  } seg_state_t;

  localparam logic SEG_ADDR_DATA  = 1'b0;
  localparam logic SEG_ADDR_BLINK = 1'b1;

  localparam logic SEG_REQ_CPU = 1'b0;
  localparam logic SEG_REQ_DBG = 1'b1;

  localparam int SEG_DIGITS = 8;

  function automatic logic [31:0] nibble_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [7:0]  wstrb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < SEG_DIGITS; i++) begin
      if (wstrb[i]) res[4*i +: 4] = wdata[4*i +: 4];
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_blink_timer.sv
// Free-running blink phase generator; phase flips every 2**DIV_W clocks.
// Only built when SEG_BLINK_EN is defined.
`ifdef SEG_BLINK_EN
module seg_blink_timer #(
  parameter int DIV_W = 24
) (
  input  logic clk,
  input  logic rst,
  output logic blink_phase
);

  logic [DIV_W-1:0] cnt;

  // Down-counter: the step from 1 to 0 is the wrap point of the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      blink_phase <= 1'b0;
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == DIV_W'(1)) blink_phase <= ~blink_phase;
    end
  end

endmodule
`endif

// File: rtl/seg_buf_arbiter.sv
// Round-robin write arbiter owning the 8-digit seven-segment hex buffer.
// Optional per-digit blinking is enabled with the SEG_BLINK_EN macro.
//
// state        | meaning
// SEG_ST_IDLE  | waiting for a request; grant decided here
// SEG_ST_WRITE | ready pulsed to the granted requester, write committed
module seg_buf_arbiter
  import seg_buf_arbiter_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  parameter int          BLINK_DIV_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [7:0]  req0_wstrb,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [7:0]  req1_wstrb,
`ifdef SEG_BLINK_EN
  output logic [7:0]  digit_blank,
`endif
  output logic [31:0] disp_buffer,
  output logic        last_grant
);

  seg_state_t  state, state_nxt;
  logic        gnt, gnt_nxt;
  logic        commit;
  logic        w_addr;
  logic [31:0] w_data;
  logic [7:0]  w_strb;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    case (state)
      SEG_ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          state_nxt = SEG_ST_WRITE;
          if (req0_valid && req1_valid) gnt_nxt = ~last_grant;
          else                          gnt_nxt = req1_valid;
        end
      end
      SEG_ST_WRITE: state_nxt = SEG_ST_IDLE;
      default:      state_nxt = SEG_ST_IDLE;
    endcase
  end

  assign commit = (state == SEG_ST_WRITE);
  assign w_addr = gnt ? req1_addr  : req0_addr;
  assign w_data = gnt ? req1_wdata : req0_wdata;
  assign w_strb = gnt ? req1_wstrb : req0_wstrb;

  // Gated by rst so a write killed by reset never shows a handshake.
  assign req0_ready = commit && (gnt == SEG_REQ_CPU) && !rst;
  assign req1_ready = commit && (gnt == SEG_REQ_DBG) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEG_ST_IDLE;
      gnt         <= SEG_REQ_CPU;
      last_grant  <= SEG_REQ_DBG;
      disp_buffer <= RESET_VALUE;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      if (commit) begin
        last_grant <= gnt;
        if (w_addr == SEG_ADDR_DATA)
          disp_buffer <= nibble_merge(disp_buffer, w_data, w_strb);
      end
    end
  end

`ifdef SEG_BLINK_EN
  logic [7:0] blink_mask;
  logic       blink_phase;

  seg_blink_timer #(.DIV_W(BLINK_DIV_W)) u_blink_timer (
    .clk        (clk),
    .rst        (rst),
    .blink_phase(blink_phase)
  );

  // Mask bit for digit i lives in the low bit of its nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_mask  <= '0;
      digit_blank <= '0;
    end else begin
      if (commit && (w_addr == SEG_ADDR_BLINK)) begin
        for (int i = 0; i < SEG_DIGITS; i++) begin
          if (w_strb[i]) blink_mask[i] <= w_data[4*i];
        end
      end
      digit_blank <= blink_mask & {8{blink_phase}};
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (BLINK_DIV_W > 0);
`endif

endmodule

// File: tb/tb_seg_buf_arbiter.sv
// Scoreboard bench for seg_buf_arbiter: drivers queue expected writes,
// a negedge monitor checks grants, buffer contents and handshake rules.
module tb_seg_buf_arbiter;

  typedef struct {
    logic        addr;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_addr;
  logic [31:0] req0_wdata;
  logic [7:0]  req0_wstrb;
  logic        req1_valid, req1_ready, req1_addr;
  logic [31:0] req1_wdata;
  logic [7:0]  req1_wstrb;
  logic [31:0] disp_buffer;
  logic        last_grant;
`ifdef SEG_BLINK_EN
  logic [7:0]  digit_blank;
`endif

  seg_buf_arbiter #(.RESET_VALUE(32'h0000_0000), .BLINK_DIV_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_wstrb (req0_wstrb),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_wstrb (req1_wstrb),
`ifdef SEG_BLINK_EN
    .digit_blank(digit_blank),
`endif
    .disp_buffer(disp_buffer),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_run    = 0;

  txn_t        q0[$];
  txn_t        q1[$];
  int          ready_log[$];
  int          last_ready_cyc;
  logic [31:0] ref_buf = 32'h0;
  logic        model_last = 1'b1;
  logic        pv0 = 1'b0, pv1 = 1'b0;
  logic        pend = 1'b0;
  logic        pend_id = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) n_run <= 0;
    else     n_run <= n_run + 1;
  end

  task automatic check(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] cur,
                                            input logic [31:0] wd,
                                            input logic [7:0]  ws);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 8; i++) if (ws[i]) r[4*i +: 4] = wd[4*i +: 4];
    return r;
  endfunction

  // Monitor: pops the expected transaction whenever a ready pulse appears.
  always @(negedge clk) begin
    if (rst) begin
      check(!(req0_ready || req1_ready), "no_ready_in_reset",
            {30'b0, req1_ready, req0_ready}, 32'h0);
      ref_buf    = 32'h0;
      model_last = 1'b1;
      pend       = 1'b0;
      pv0        = 1'b0;
      pv1        = 1'b0;
    end else begin
      if (pend) begin
        check(disp_buffer == ref_buf, "buffer_after_commit", disp_buffer, ref_buf);
        check(last_grant == pend_id, "last_grant", {31'b0, last_grant}, {31'b0, pend_id});
        pend = 1'b0;
      end
      check(!(req0_ready && req1_ready), "single_ready",
            {30'b0, req1_ready, req0_ready}, 32'h0);
      if (req0_ready ^ req1_ready) begin
        logic id, exp_id;
        txn_t t;
        id     = req1_ready;
        exp_id = (pv0 && pv1) ? ~model_last : pv1;
        check(id == exp_id, "grant_order", {31'b0, id}, {31'b0, exp_id});
        if ((id ? q1.size() : q0.size()) == 0) begin
          check(1'b0, "unexpected_ready", {31'b0, id}, 32'h0);
        end else begin
          t = id ? q1.pop_front() : q0.pop_front();
          if (t.addr == 1'b0) ref_buf = merge_ref(ref_buf, t.wdata, t.wstrb);
        end
        model_last = id;
        pend       = 1'b1;
        pend_id    = id;
        ready_log.push_back(int'(id));
        last_ready_cyc = cyc;
      end
      pv0 = req0_valid;
      pv1 = req1_valid;
    end
  end

  // Call at posedge+1; returns at posedge+1 after the handshake.
  task automatic do_write(input logic id, input logic addr, input logic [31:0] wd,
                          input logic [7:0] ws, output int lat);
    txn_t t;
    bit   done;
    t.addr = addr; t.wdata = wd; t.wstrb = ws;
    if (id) begin
      q1.push_back(t);
      req1_addr = addr; req1_wdata = wd; req1_wstrb = ws; req1_valid = 1'b1;
    end else begin
      q0.push_back(t);
      req0_addr = addr; req0_wdata = wd; req0_wstrb = ws; req0_valid = 1'b1;
    end
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
      if (id ? req1_ready : req0_ready) done = 1'b1;
    end
    if (!done) check(1'b0, "ready_timeout", {31'b0, id}, 32'h1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic rand_stream(input logic id, input int n, input int max_gap);
    int lat;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      do_write(id, ($urandom_range(0, 3) == 0), $urandom, 8'($urandom), lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] snap;
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = 1'b0; req0_wdata = '0; req0_wstrb = '0;
    req1_valid = 1'b0; req1_addr = 1'b0; req1_wdata = '0; req1_wstrb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check(disp_buffer == 32'h0, "reset_buffer", disp_buffer, 32'h0);
    check(req0_ready == 1'b0, "reset_ready0", {31'b0, req0_ready}, 32'h0);
    check(req1_ready == 1'b0, "reset_ready1", {31'b0, req1_ready}, 32'h0);
    check(last_grant == 1'b1, "reset_last_grant", {31'b0, last_grant}, 32'h1);
    @(posedge clk); #1;

    // Contention straight out of reset: req0 first, then strict alternation.
    begin
      int start_cyc;
      ready_log.delete();
      start_cyc = cyc;
      fork
        for (int k = 0; k < 4; k++) do_write(1'b0, 1'b0, $urandom, 8'hFF, lat);
        for (int k = 0; k < 4; k++) do_write(1'b1, 1'b0, $urandom, 8'($urandom), lat);
      join
      check(ready_log.size() == 8, "contention_count", ready_log.size(), 32'd8);
      for (int i = 0; i < ready_log.size(); i++)
        check(ready_log[i] == (i % 2), "contention_order", ready_log[i], i % 2);
      check((last_ready_cyc - start_cyc) == 15, "contention_cycles",
            last_ready_cyc - start_cyc, 32'd15);
    end

    do_write(1'b0, 1'b0, 32'h1234_5678, 8'hFF, lat);
    check(lat == 2, "single_latency", lat, 32'd2);
    check(disp_buffer == 32'h1234_5678, "single_write", disp_buffer, 32'h1234_5678);

    do_write(1'b1, 1'b0, 32'hAAAA_AAAA, 8'h0F, lat);
    check(disp_buffer == 32'h1234_AAAA, "partial_write", disp_buffer, 32'h1234_AAAA);

    do_write(1'b0, 1'b0, 32'hFFFF_FFFF, 8'h00, lat);
    check(lat == 2, "zero_strobe_ready", lat, 32'd2);
    check(disp_buffer == 32'h1234_AAAA, "zero_strobe_hold", disp_buffer, 32'h1234_AAAA);

    do_write(1'b1, 1'b1, 32'h1000_0001, 8'h81, lat);
    check(lat == 2, "blink_addr_ready", lat, 32'd2);
    check(disp_buffer == 32'h1234_AAAA, "blink_addr_no_data", disp_buffer, 32'h1234_AAAA);

    fork
      rand_stream(1'b0, 30, 3);
      rand_stream(1'b1, 30, 3);
    join
    check(q0.size() == 0 && q1.size() == 0, "scoreboard_drained",
          q0.size() + q1.size(), 32'h0);

    // Reset lands on the WRITE cycle of a req0 write.
    snap = disp_buffer;
    req0_addr = 1'b0; req0_wdata = 32'hDEAD_BEEF; req0_wstrb = 8'hFF; req0_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check(req0_ready == 1'b0, "midop_no_ready", {31'b0, req0_ready}, 32'h0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check(disp_buffer == 32'h0, "midop_buffer_reset", disp_buffer, 32'h0);
    check(last_grant == 1'b1, "midop_last_grant", {31'b0, last_grant}, 32'h1);
    check(snap != 32'hDEAD_BEEF || disp_buffer == 32'h0, "midop_dropped", disp_buffer, 32'h0);
    @(posedge clk); #1;
    do_write(1'b0, 1'b0, 32'h0BAD_F00D, 8'h3C, lat);
    check(lat == 2, "midop_idle_after", lat, 32'd2);
    check(disp_buffer == 32'h00AD_F000, "midop_rewrite", disp_buffer, 32'h00AD_F000);

`ifdef SEG_BLINK_EN
    do_write(1'b0, 1'b1, 32'h1000_0001, 8'h81, lat);
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 0; k < 48; k++) begin
      logic [7:0] exp_blank;
      @(negedge clk);
      exp_blank = (((n_run - 1) >> 4) & 1) != 0 ? 8'h81 : 8'h00;
      check(digit_blank == exp_blank, "digit_blank", {24'b0, digit_blank}, {24'b0, exp_blank});
    end
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
